rate_tick_gen: RTL and testbench
================================

# rate_tick_gen

Rate-selectable tick generator that sits directly upstream of the top-level count/display logic. It cleans the raw frequency-select pushbutton (KEY[1]) and steps through four rates on each debounced press. It emits a one-cycle `tick` enable at the selected rate; the downstream counter and HEX decode advance only on `tick`. The block runs on the 10 MHz board clock with the board reset on KEY[0].

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 200000. Consecutive stable cycles required to accept a button level; must be ≥1.
- `DIV0`, default 10000000. Clocks per tick at rate 0; must be ≥1.
- `DIV1`, default 5000000. Clocks per tick at rate 1.
- `DIV2`, default 2000000. Clocks per tick at rate 2.
- `DIV3`, default 1000000. Clocks per tick at rate 3.

Ports:
- `ADC_CLK_10`  in  1  — single clock, all state on rising edge.
- `KEY0`  in  1  — reset, asynchronous, active-low (driven from KEY[0]).
- `key1_n`  in  1  — raw frequency button, asynchronous, pressed = 0.
- `run`  in  1  — tick enable (SW[0]); synchronous level.
- `tick`  out  1  — registered one-cycle pulse at the selected rate.
- `press`  out  1  — registered one-cycle pulse per accepted press.
- `rate_sel`  out  2  — current rate index, 0..3.

## Operation
- Synchronizer: 2 flops on `key1_n`, both reset to 1.
- Debounce: the stable level resets to 1, and the debounce counter resets to 0.
  - The counter clears whenever the synced input equals the stable level.
  - Otherwise it increments.
  - When it reaches `DEBOUNCE_CYCLES`-1 while the input still differs, the stable level flips and the counter clears.
- Press detect: a stable 1→0 transition asserts `press` for exactly one cycle. A 0→1 transition (release) produces nothing.
- Rate select: on `press`, `rate_sel` increments modulo 4 (3→0 wrap). The selected divisor is `DIVn` for n = `rate_sel`.
- Prescaler counter `cnt` has width clog2 of the largest DIV.
  - Press takes priority: on the same edge as the press, `cnt`←0 and no tick is issued, even if the terminal count coincides.
  - Otherwise, with `run`=1 and `cnt` = DIVn−1: `cnt`←0 and `tick`←1.
  - Otherwise, with `run`=1: `cnt`+1 and `tick`←0.
  - With `run`=0: `cnt` holds and `tick`←0.
- With DIVn = 1 and `run`=1, `tick` is continuously high.
- Reset (`KEY0`=0) at any time, including mid-debounce or mid-count, forces these values:
  - `tick`=0, `press`=0, `rate_sel`=0, `cnt`=0.
  - Debounce counter 0, stable level 1, sync flops 1.

## Timing
- All outputs are registered; none is combinational from inputs.
- Press latency: `key1_n` goes low before edge 1 and stays low. `press` and the new `rate_sel` both appear after edge `DEBOUNCE_CYCLES`+3, and `press` drops after the next edge.
- After a press, the first tick at the new rate appears DIVn edges later, provided `run` stays 1.
- Reset release: with `run`=1, the first tick appears DIV0 edges after the first edge with `KEY0`=1.
- A glitch shorter than `DEBOUNCE_CYCLES` synced cycles produces no `press`, and the debounce counter restarts.
- `run` deasserting mid-period freezes `cnt`. Reasserting resumes from the frozen value; no phase is lost.

## Structure
- Shared include `rate_defs.vh`: `RATE_W`=2, default DIV0..DIV3, default `DEBOUNCE_CYCLES`. The top-level display logic reuses these.
- One sub-module, `btn_debounce`. It contains the synchronizer, the debounce counter and the fall-edge pulse, and outputs `press`. It is reusable for KEY0-style buttons elsewhere.
- `rate_tick_gen` holds the rate register, the divisor mux and the prescaler.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, DIV0=2, DIV1=3, DIV2=5, DIV3=8, clock 20 ns period.
1. Hold `KEY0`=0 for 3 cycles with `run`=1 and `key1_n`=1 → all outputs 0. Release reset → `tick` high after edges 2, 4, 6…, never two cycles in a row.
2. Drive `key1_n` low for 3 cycles, then high → no `press`; `rate_sel` stays 0; tick cadence is unchanged.
3. Drive `key1_n` low and hold for 10 cycles, then release → exactly one `press`, after edge 7 from the low. `rate_sel`=1, `cnt` restarts, then ticks every 3 cycles. The release produces no `press`.
4. Four clean presses → `rate_sel` steps 1, 2, 3, 0. Measured tick periods are 3, 5, 8, 2.
5. At rate 3 with `cnt`=5, set `run`=0 for 6 cycles, then `run`=1 → no ticks while `run`=0; the next tick arrives 3 edges after re-enable.
6. Assert `KEY0` low asynchronously, mid-debounce and mid-count at rate 2 → `rate_sel`, `tick` and `press` go 0 without a clock edge. After release, behaviour matches scenario 1.

Source files
------------

// File: rtl/rate_tick_gen_pkg.sv
// Shared widths and default rates for the rate tick generator and the display logic that consumes it.
`timescale 1ns/1ps
package rate_tick_gen_pkg;

  localparam int unsigned RATE_W              = 2;
  localparam int unsigned DEF_DIV0            = 10_000_000;
  localparam int unsigned DEF_DIV1            = 5_000_000;
  localparam int unsigned DEF_DIV2            = 2_000_000;
  localparam int unsigned DEF_DIV3            = 1_000_000;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 200_000;

  // Counter width able to hold 0..max_val-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/rate_tick_gen_if.sv
// Button/run inputs and tick/press/rate outputs of the rate tick generator.
`timescale 1ns/1ps
interface rate_tick_gen_if;
  import rate_tick_gen_pkg::*;

  logic              key1_n;
  logic              run;
  logic              tick;
  logic              press;
  logic [RATE_W-1:0] rate_sel;

  modport master (output key1_n, output run, input tick, input press, input rate_sel);
  modport slave  (input key1_n, input run, output tick, output press, output rate_sel);

endinterface

// File: rtl/btn_debounce.sv
// Synchronizes and debounces an active-low pushbutton; pulses o_press once per accepted press.
`timescale 1ns/1ps
module btn_debounce
  import rate_tick_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_press,
  output logic o_fall_c
);

  localparam int unsigned     DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      r_sync;
  logic            r_stable;
  logic            r_stable_d;
  logic            r_press;
  logic [DB_W-1:0] r_db_cnt;
  logic            w_synced;

  assign w_synced = r_sync[1];
  assign o_fall_c = r_stable_d & ~r_stable;
  assign o_press  = r_press;

  // Two-flop synchronizer, idles at the released level.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], i_btn_n};
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= 1'b1;
      r_db_cnt <= '0;
    end else if (w_synced == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == DB_LAST) begin
      r_stable <= w_synced;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable_d <= 1'b1;
      r_press    <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_press    <= o_fall_c;
    end
  end

endmodule

// File: rtl/rate_tick_gen.sv
// Button-selected four-rate tick generator; emits a one-cycle tick every DIVn clocks while run is high.
`timescale 1ns/1ps
module rate_tick_gen
  import rate_tick_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DIV0            = DEF_DIV0,
  parameter int unsigned DIV1            = DEF_DIV1,
  parameter int unsigned DIV2            = DEF_DIV2,
  parameter int unsigned DIV3            = DEF_DIV3
) (
  input  logic          ADC_CLK_10,
  input  logic          KEY0,
  rate_tick_gen_if.slave bus
);

  localparam int unsigned DIV_MAX = max4(DIV0, DIV1, DIV2, DIV3);
  localparam int unsigned CNT_W   = cnt_width(DIV_MAX);

  logic              w_press;
  logic              w_fall;
  logic [CNT_W-1:0]  w_div_last;
  logic [RATE_W-1:0] r_rate_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_tick;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .i_clk    (ADC_CLK_10),
    .i_rst_n  (KEY0),
    .i_btn_n  (bus.key1_n),
    .o_press  (w_press),
    .o_fall_c (w_fall)
  );

  // Rate index advances on the same edge the press pulse is registered.
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0)       r_rate_sel <= '0;
    else if (w_fall) r_rate_sel <= r_rate_sel + RATE_W'(1);
  end

  always_comb begin
    w_div_last = CNT_W'(DIV0 - 1);
    case (r_rate_sel)
      RATE_W'(0): w_div_last = CNT_W'(DIV0 - 1);
      RATE_W'(1): w_div_last = CNT_W'(DIV1 - 1);
      RATE_W'(2): w_div_last = CNT_W'(DIV2 - 1);
      RATE_W'(3): w_div_last = CNT_W'(DIV3 - 1);
    endcase
  end

  // Prescaler: a press restarts the period and suppresses any coincident tick.
  always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
    if (!KEY0) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (w_fall) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (bus.run) begin
      if (r_cnt == w_div_last) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign bus.tick     = r_tick;
  assign bus.press    = w_press;
  assign bus.rate_sel = r_rate_sel;

endmodule

// File: tb/tb_rate_tick_gen.sv
// Directed bench for rate_tick_gen with short debounce and divisors.
`timescale 1ns/1ps
module tb_rate_tick_gen;

  localparam int unsigned DEB = 4;
  localparam int unsigned D0  = 2;
  localparam int unsigned D1  = 3;
  localparam int unsigned D2  = 5;
  localparam int unsigned D3  = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  rate_tick_gen_if bus();

  rate_tick_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .DIV0            (D0),
    .DIV1            (D1),
    .DIV2            (D2),
    .DIV3            (D3)
  ) dut (
    .ADC_CLK_10 (clk),
    .KEY0       (rst_n),
    .bus        (bus)
  );

  initial forever #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic t, input logic p, input logic [1:0] r);
    check({tag, ".tick"},     32'(bus.tick),     32'(t));
    check({tag, ".press"},    32'(bus.press),    32'(p));
    check({tag, ".rate_sel"}, 32'(bus.rate_sel), 32'(r));
  endtask

  // Settle, press, check latency and new rate, then measure two tick periods.
  task automatic do_press(input logic [1:0] exp_rate, input int exp_div);
    int lat;
    int n;
    bit seen;
    bus.key1_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("settle.press", 32'(bus.press), 32'd0);
    end
    bus.key1_n = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      step();
      lat++;
      seen = bus.press;
    end
    check("press.latency", 32'(lat), 32'(DEB + 3));
    check("press.rate_sel", 32'(bus.rate_sel), 32'(exp_rate));
    check("press.no_tick", 32'(bus.tick), 32'd0);
    bus.key1_n = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (n == 1) check("press.width", 32'(bus.press), 32'd0);
    end while (!bus.tick && n < 40);
    check("period.first", 32'(n), 32'(exp_div));
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.tick && n < 40);
    check("period.next", 32'(n), 32'(exp_div));
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.run    = 1'b1;
    bus.key1_n = 1'b1;

    // Reset hold, then rate-0 cadence: tick after every even edge.
    for (int i = 0; i < 3; i++) begin
      step();
      check_outs("reset", 1'b0, 1'b0, 2'd0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_outs("rate0", (i % 2 == 0), 1'b0, 2'd0);
    end

    // Three-cycle glitch is rejected; cadence continues.
    bus.key1_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 3) bus.key1_n = 1'b1;
      check_outs("glitch", (i % 2 == 0), 1'b0, 2'd0);
    end

    // Held press: one pulse after edge 7, rate 1, ticks every 3; release is silent.
    bus.key1_n = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 10) bus.key1_n = 1'b1;
      if (k < 7)
        check_outs("hold", (k % 2 == 0), 1'b0, 2'd0);
      else
        check_outs("hold", (k > 7) && ((k - 7) % 3 == 0), (k == 7), 2'd1);
    end

    // Stepping through every rate, including the 3->0 wrap.
    do_press(2'd2, D2);
    do_press(2'd3, D3);
    do_press(2'd0, D0);
    do_press(2'd1, D1);
    do_press(2'd2, D2);
    do_press(2'd3, D3);

    // run gating at rate 3: freeze at cnt=5, resume without losing phase.
    for (int i = 0; i < 5; i++) begin
      step();
      check("pre_freeze.tick", 32'(bus.tick), 32'd0);
    end
    bus.run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("frozen.tick", 32'(bus.tick), 32'd0);
    end
    bus.run = 1'b1;
    step();
    check("resume1.tick", 32'(bus.tick), 32'd0);
    step();
    check("resume2.tick", 32'(bus.tick), 32'd0);
    step();
    check("resume3.tick", 32'(bus.tick), 32'd1);

    // Async reset at rate 2 while debouncing and with tick high.
    do_press(2'd0, D0);
    do_press(2'd1, D1);
    do_press(2'd2, D2);
    bus.key1_n = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      check_outs("mid", (i == 5), 1'b0, 2'd2);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 2'd0);
    bus.key1_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_outs("reset2", 1'b0, 1'b0, 2'd0);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check_outs("rate0_again", (i % 2 == 0), 1'b0, 2'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
